fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Front-end fetch stage that drives the instruction cache read port and buffers returned words for decode.
// - Generates sequential word addresses from a PC register and issues one read per cycle when buffer credit allows.
// - Captures each response {pc, instr} one cycle after issue into a DEPTH-entry FIFO and presents the FIFO to decode with a valid/ready handshake.
// - A redirect (branch/jump) flushes the FIFO, drops the in-flight response and restarts fetch at the target.
// PARAMETERS
// - DEPTH     4        FIFO entries; power of two, >= 2
// - RESET_PC  16'h0000 first fetch address after reset
// PORTS
// - clk             in   1   clock, all state on posedge
// - rst_n           in   1   reset, asynchronous, active-low
// - ic_rd_en        out  1   cache read strobe
// - ic_rd_dest      out  16  cache word address
// - ic_rd_out       in   16  cache data, valid the cycle after ic_rd_en
// - ic_pc_out       in   16  address that produced ic_rd_out
// - redirect_valid  in   1   flush and refetch from redirect_pc
// - redirect_pc     in   16  redirect target word address
// - instr_valid     out  1   FIFO head valid to decode
// - instr_ready     in   1   decode accepts head
// - instr_data      out  16  head instruction word
// - instr_pc        out  16  head instruction address
// - fifo_count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
// - Reset (rst_n low, async): fetch_pc=RESET_PC, resp_pending=0, rd/wr ptrs=0, count=0; ic_rd_en forced 0, instr_valid=0, instr_data=0, instr_pc=0, fifo_count=0.
// - Cache latency is exactly 1 cycle. resp_pending <= ic_rd_en; it marks ic_rd_out/ic_pc_out valid this cycle (the cache holds stale data otherwise, so data change is never used as valid).
// - Issue (combinational): ic_rd_en = redirect_valid | (count + resp_pending + 1 <= DEPTH). Credit uses registered count only; no credit for a same-cycle pop.
// - ic_rd_dest = redirect_valid ? redirect_pc : fetch_pc. On issue, fetch_pc <= ic_rd_dest + 1, 16-bit wrap (16'hFFFF -> 16'h0000).
// - Push: resp_pending & ~redirect_valid writes {ic_pc_out, ic_rd_out} at wr_ptr. Credit rule guarantees a push never occurs when full.
// - Pop: instr_valid & instr_ready & ~redirect_valid advances rd_ptr. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
// - instr_valid = (count != 0). instr_data/instr_pc = head entry when valid, else 0.
// - Redirect cycle: next count=0, ptrs=0, arriving response dropped, no pop, and the redirect_pc read issues the same cycle. The first post-redirect word is visible 2 cycles later (1 cycle with bypass).
// - Redirect while empty or idle: same as above, no special case. Back-to-back redirects: the last one wins; each drops the previous cycle's response.
// - rst_n low mid-stream: all state cleared immediately; the in-flight response is ignored because resp_pending clears.
// CONFIGURATION
// - FETCH_BYPASS_EN defined: when count==0 & resp_pending & ~redirect_valid, instr_valid=1 and instr_data/instr_pc come directly from ic_rd_out/ic_pc_out. If instr_ready, no push occurs; otherwise the word is pushed normally.
// - Undefined: responses always pass through the FIFO, adding 1 cycle of latency from response to instr_valid.
// TESTING
// - Reset release, instr_ready=1: ic_rd_dest 0,1,2,...; instr_pc 0,1,2,... one per cycle from cycle 2 (cycle 1 with bypass); data matches the memory image.
// - DEPTH=4, instr_ready=0: exactly 4 reads issued, then ic_rd_en=0, fifo_count=4. Raise ready: entries drain in order and issue resumes.
// - Redirect to 16'h0040 while 3 entries are queued and 1 in flight: fifo_count->0, in-flight word never appears, next instr_pc=16'h0040, then 16'h0041.
// - Sequential fetch from 16'hFFFE: instr_pc sequence FFFE, FFFF, 0000, 0001.
// - Random instr_ready with push/pop collisions at count=DEPTH-1: no overflow or underflow, order preserved, scoreboard matches the memory image.
// - Assert rst_n low mid-stream with a request in flight: outputs 0 immediately; after release, fetch restarts at RESET_PC with no stale entry.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch stage buses.
//   Cache read port: ic_rd_en, ic_rd_dest (fetch -> cache) and ic_rd_out, ic_pc_out (cache -> fetch).
//   Redirect: redirect_valid, redirect_pc (core -> fetch).
//   Decode port: instr_valid, instr_data, instr_pc, fifo_count (fetch -> decode) and instr_ready (decode -> fetch).
//   The master modport is the fetch unit; the slave modport is everything around it.
interface fetch_unit_if #(
    parameter int DEPTH = 4
);
    logic                     ic_rd_en;
    logic [15:0]              ic_rd_dest;
    logic [15:0]              ic_rd_out;
    logic [15:0]              ic_pc_out;
    logic                     redirect_valid;
    logic [15:0]              redirect_pc;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [15:0]              instr_data;
    logic [15:0]              instr_pc;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output ic_rd_en, ic_rd_dest, instr_valid, instr_data, instr_pc, fifo_count,
        input  ic_rd_out, ic_pc_out, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  ic_rd_en, ic_rd_dest, instr_valid, instr_data, instr_pc, fifo_count,
        output ic_rd_out, ic_pc_out, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with a DEPTH-entry decode FIFO and redirect flush.
//   clk, rst_n (async, active-low) plus bus (fetch_unit_if.master):
//   issues one cache read per cycle while FIFO credit allows, captures each response one cycle
//   later into the FIFO and presents the head to decode via instr_valid/instr_ready.
//   Optional macro FETCH_BYPASS_EN: an empty FIFO forwards the arriving response straight to decode.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic           clk,
    input logic           rst_n,
    fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   fetch_pc;
    logic          resp_pending;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   mem_pc    [DEPTH];
    logic [15:0]   mem_instr [DEPTH];
    logic [CW:0]   need;
    logic          fifo_nz;
    logic          byp;
    logic          push;
    logic          pop;

    // Credit counts the in-flight response so a push can never land on a full FIFO.
    assign need    = {1'b0, count} + CW'(resp_pending) + 1'b1;
    assign fifo_nz = count != '0;

`ifdef FETCH_BYPASS_EN
    assign byp = !fifo_nz && resp_pending && !bus.redirect_valid;
`else
    assign byp = 1'b0;
`endif

    assign push = resp_pending && !bus.redirect_valid && !(byp && bus.instr_ready);
    assign pop  = fifo_nz && bus.instr_ready && !bus.redirect_valid;

    assign bus.ic_rd_en    = rst_n && (bus.redirect_valid || need <= (CW+1)'(DEPTH));
    assign bus.ic_rd_dest  = bus.redirect_valid ? bus.redirect_pc : fetch_pc;
    assign bus.instr_valid = fifo_nz || byp;
    assign bus.instr_data  = fifo_nz ? mem_instr[rd_ptr] : byp ? bus.ic_rd_out : 16'h0000;
    assign bus.instr_pc    = fifo_nz ? mem_pc[rd_ptr] : byp ? bus.ic_pc_out : 16'h0000;
    assign bus.fifo_count  = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            resp_pending <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            resp_pending <= bus.ic_rd_en;
            if (bus.ic_rd_en)
                fetch_pc <= bus.ic_rd_dest + 16'd1;
            if (bus.redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= bus.ic_pc_out;
            mem_instr[wr_ptr] <= bus.ic_rd_out;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a 1-cycle cache model.
module tb_fetch_unit;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errs = 0;

    fetch_unit_if #(.DEPTH(DEPTH)) bus ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] img(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    // Cache: data for the strobed address appears the next cycle and is held otherwise.
    always @(posedge clk)
        if (bus.ic_rd_en) begin
            bus.ic_rd_out <= img(bus.ic_rd_dest);
            bus.ic_pc_out <= bus.ic_rd_dest;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        tick;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_seq(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check({tag, "_dest"}, 32'(bus.ic_rd_dest), 32'(k));
            check({tag, "_en"}, 32'(bus.ic_rd_en), 32'd1);
            check({tag, "_valid"}, 32'(bus.instr_valid), 32'(k >= LAT));
            if (k >= LAT) begin
                check({tag, "_pc"}, 32'(bus.instr_pc), 32'(k - LAT));
                check({tag, "_data"}, 32'(bus.instr_data), 32'(img(16'(k - LAT))));
            end
            tick;
        end
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_en"}, 32'(bus.ic_rd_en), 32'd0);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_cnt"}, 32'(bus.fifo_count), 32'd0);
        check({tag, "_data"}, 32'(bus.instr_data), 32'd0);
        check({tag, "_pc"}, 32'(bus.instr_pc), 32'd0);
    endtask

    initial begin
        int n;
        int exp_pc;
        int maxc;
        rst_n = 1'b0;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (2) tick;
        reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        run_seq("seq", 8);

        // Back-pressure: exactly DEPTH reads, then drain in order.
        bus.instr_ready = 1'b0;
        reset_dut;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.ic_rd_en) n++;
            tick;
        end
        check("full_reads", 32'(n), 32'(DEPTH));
        check("full_en", 32'(bus.ic_rd_en), 32'd0);
        check("full_cnt", 32'(bus.fifo_count), 32'(DEPTH));
        bus.instr_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(bus.instr_valid), 32'd1);
            check("drain_pc", 32'(bus.instr_pc), 32'(i));
            check("drain_data", 32'(bus.instr_data), 32'(img(16'(i))));
            tick;
        end

        // Redirect with 3 queued and 1 in flight.
        bus.instr_ready = 1'b0;
        reset_dut;
        repeat (4) tick;
        check("redir_pre_cnt", 32'(bus.fifo_count), 32'd3);
        check("redir_pre_en", 32'(bus.ic_rd_en), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        check("redir_en", 32'(bus.ic_rd_en), 32'd1);
        check("redir_dest", 32'(bus.ic_rd_dest), 32'h0040);
        tick;
        bus.redirect_valid = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        check("redir_cnt", 32'(bus.fifo_count), 32'd0);
        repeat (LAT - 1) begin
            check("redir_gap", 32'(bus.instr_valid), 32'd0);
            tick;
        end
        check("redir_pc0", 32'(bus.instr_pc), 32'h0040);
        check("redir_data0", 32'(bus.instr_data), 32'(img(16'h0040)));
        tick;
        check("redir_pc1", 32'(bus.instr_pc), 32'h0041);

        // Address wrap through 16'hFFFF.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        #1;
        check("wrap_dest", 32'(bus.ic_rd_dest), 32'hFFFE);
        tick;
        bus.redirect_valid = 1'b0;
        #1;
        repeat (LAT - 1) tick;
        for (int i = 0; i < 4; i++) begin
            check("wrap_pc", 32'(bus.instr_pc), 32'(16'(16'hFFFE + i)));
            check("wrap_data", 32'(bus.instr_data), 32'(img(16'(16'hFFFE + i))));
            tick;
        end

        // Random decode back-pressure against the memory image.
        reset_dut;
        exp_pc = 0;
        maxc = 0;
        for (int c = 0; c < 400; c++) begin
            bus.instr_ready = (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            #1;
            if (32'(bus.fifo_count) > maxc) maxc = 32'(bus.fifo_count);
            if (bus.instr_valid && bus.instr_ready) begin
                check("rnd_pc", 32'(bus.instr_pc), 32'(16'(exp_pc)));
                check("rnd_data", 32'(bus.instr_data), 32'(img(16'(exp_pc))));
                exp_pc++;
            end
            tick;
        end
        check("rnd_max", 32'(maxc), 32'(DEPTH));
        check("rnd_progress", 32'(exp_pc >= 100), 32'd1);

        // Reset mid-stream with a read in flight.
        bus.instr_ready = 1'b1;
        reset_dut;
        repeat (3) tick;
        check("mid_pre_en", 32'(bus.ic_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        reset_outputs("mid");
        tick;
        rst_n = 1'b1;
        #1;
        run_seq("mid_seq", 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end
endmodule
